// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: instruction encodings,
// fixed vectors, opcode values shared with the decoder, and the per-cycle action.
package fetch_pkg;

    localparam logic [15:0] NOP_INSTR  = 16'h0800;
    localparam logic [15:0] RESET_VEC  = 16'h0000;
    localparam logic [15:0] SIIC_VEC   = 16'h0002;

    // Opcodes live in instr[15:11]; NOP_INSTR decodes to OP_NOP.
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;

    typedef enum logic [2:0] {
        ACT_HALTED,
        ACT_REDIRECT,
        ACT_SIIC,
        ACT_RTI,
        ACT_HALT,
        ACT_STALL,
        ACT_IMEM_STALL,
        ACT_NORMAL
    } fetch_action_t;

    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register. A bubble replaces the instruction with a NOP and
// clears valid while leaving pc_plus2 untouched.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        bubble,
    input  logic [15:0] next_instr,
    input  logic [15:0] next_pc_plus2,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= RESET_VEC;
            valid    <= 1'b0;
        end else if (we) begin
            if (bubble) begin
                instr <= NOP_INSTR;
                valid <= 1'b0;
            end else begin
                instr    <= next_instr;
                pc_plus2 <= next_pc_plus2;
                valid    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, exception PC and halt flag, and resolves
// the per-cycle priority between halt, redirect, traps, stalls and normal fetch.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_stall,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        siic,
    input  logic        rti,
    input  logic        halt_dec,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic [15:0] epc,
    output logic        halted
);

    logic [15:0]   pc;
    logic [15:0]   pc_next;
    logic          pc_we;
    logic          ifid_we;
    logic          ifid_bubble;
    logic          epc_we;
    logic          halt_set;
    fetch_action_t action;

    assign imem_addr = pc;

    // Priority order matters: a redirect squashes any trap or halt in decode.
    always_comb begin
        if (halted)          action = ACT_HALTED;
        else if (redirect)   action = ACT_REDIRECT;
        else if (siic)       action = ACT_SIIC;
        else if (rti)        action = ACT_RTI;
        else if (halt_dec)   action = ACT_HALT;
        else if (stall)      action = ACT_STALL;
        else if (imem_stall) action = ACT_IMEM_STALL;
        else                 action = ACT_NORMAL;
    end

    always_comb begin
        pc_next     = pc;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_bubble = 1'b0;
        epc_we      = 1'b0;
        halt_set    = 1'b0;
        case (action)
            ACT_HALTED: ;
            ACT_REDIRECT: begin
                pc_next     = redirect_pc;
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                ifid_bubble = 1'b1;
            end
            ACT_SIIC: begin
                pc_next     = SIIC_VEC;
                pc_we       = 1'b1;
                epc_we      = 1'b1;
                ifid_we     = 1'b1;
                ifid_bubble = 1'b1;
            end
            ACT_RTI: begin
                pc_next     = epc;
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                ifid_bubble = 1'b1;
            end
            ACT_HALT: begin
                halt_set    = 1'b1;
                ifid_we     = 1'b1;
                ifid_bubble = 1'b1;
            end
            ACT_STALL: ;
            ACT_IMEM_STALL: begin
                ifid_we     = 1'b1;
                ifid_bubble = 1'b1;
            end
            default: begin
                pc_next = pc_inc(pc);
                pc_we   = 1'b1;
                ifid_we = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_VEC;
            epc    <= RESET_VEC;
            halted <= 1'b0;
        end else begin
            if (pc_we)    pc     <= pc_next;
            if (epc_we)   epc    <= ifid_pc_plus2;
            if (halt_set) halted <= 1'b1;
        end
    end

    ifid_reg u_ifid (
        .clk          (clk),
        .rst          (rst),
        .we           (ifid_we),
        .bubble       (ifid_bubble),
        .next_instr   (imem_data),
        .next_pc_plus2(pc_inc(pc)),
        .instr        (ifid_instr),
        .pc_plus2     (ifid_pc_plus2),
        .valid        (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run, all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_stall;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        siic;
    logic        rti;
    logic        halt_dec;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic [15:0] epc;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [15:0] m_pc, m_instr, m_pp2, m_epc;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_stall   (imem_stall),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .siic         (siic),
        .rti          (rti),
        .halt_dec     (halt_dec),
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus2(ifid_pc_plus2),
        .ifid_valid   (ifid_valid),
        .epc          (epc),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0800; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_epc = 16'h0000; m_halted = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0800;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        if (rst) model_reset();
        else if (m_halted) begin end
        else if (redirect) begin m_pc = redirect_pc; model_bubble(); end
        else if (siic) begin m_epc = m_pp2; m_pc = 16'h0002; model_bubble(); end
        else if (rti) begin m_pc = m_epc; model_bubble(); end
        else if (halt_dec) begin m_halted = 1'b1; model_bubble(); end
        else if (stall) begin end
        else if (imem_stall) model_bubble();
        else begin
            m_instr = mem_word(m_pc);
            m_pp2   = 16'((32'(m_pc) + 2) % 65536);
            m_valid = 1'b1;
            m_pc    = m_pp2;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},     imem_addr,             m_pc);
        check({tag, ".instr"},  ifid_instr,            m_instr);
        check({tag, ".pp2"},    ifid_pc_plus2,         m_pp2);
        check({tag, ".valid"},  {15'd0, ifid_valid},   {15'd0, m_valid});
        check({tag, ".epc"},    epc,                   m_epc);
        check({tag, ".halted"}, {15'd0, halted},       {15'd0, m_halted});
    endtask

    task automatic idle_inputs();
        imem_stall = 0; stall = 0; redirect = 0; redirect_pc = 16'h0;
        siic = 0; rti = 0; halt_dec = 0;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // three normal fetches from the reset vector
        check("n0.addr", imem_addr, 16'h0000);
        cycle("n0");
        check("n0.pp2", ifid_pc_plus2, 16'h0002);
        check("n0.valid", {15'd0, ifid_valid}, 16'h0001);
        check("n1.addr", imem_addr, 16'h0002);
        cycle("n1");
        check("n1.pp2", ifid_pc_plus2, 16'h0004);
        check("n2.addr", imem_addr, 16'h0004);

        // two-cycle decode stall at PC=4
        stall = 1;
        cycle("st0");
        cycle("st1");
        check("st.pc", imem_addr, 16'h0004);
        check("st.pp2", ifid_pc_plus2, 16'h0004);
        stall = 0;
        cycle("n2");
        check("n2.pp2", ifid_pc_plus2, 16'h0006);
        check("n2.instr", ifid_instr, mem_word(16'h0004));

        // redirect beats stall and halt_dec
        redirect = 1; redirect_pc = 16'h0100; stall = 1; halt_dec = 1;
        cycle("rd");
        check("rd.valid", {15'd0, ifid_valid}, 16'h0000);
        check("rd.pc", imem_addr, 16'h0100);
        check("rd.halted", {15'd0, halted}, 16'h0000);
        idle_inputs();
        cycle("rd.next");
        check("rd.target", ifid_instr, mem_word(16'h0100));

        // siic then rti
        redirect = 1; redirect_pc = 16'h001E;
        cycle("pre_siic");
        redirect = 0;
        cycle("pre_siic2");
        check("pre_siic.pp2", ifid_pc_plus2, 16'h0020);
        siic = 1;
        cycle("siic");
        check("siic.epc", epc, 16'h0020);
        check("siic.pc", imem_addr, 16'h0002);
        siic = 0;
        cycle("post_siic0");
        cycle("post_siic1");
        rti = 1;
        cycle("rti");
        check("rti.pc", imem_addr, 16'h0020);
        check("rti.epc", epc, 16'h0020);
        rti = 0;

        // randomized mix of everything except halt
        for (int i = 0; i < 400; i++) begin
            imem_stall  = ($urandom_range(0, 3) == 0);
            stall       = ($urandom_range(0, 4) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 16'($urandom);
            siic        = ($urandom_range(0, 19) == 0);
            rti         = ($urandom_range(0, 19) == 0);
            halt_dec    = 0;
            cycle("rand");
        end
        idle_inputs();

        // reset asserted mid-stall clears everything at once
        stall = 1;
        cycle("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst_stall");
        cycle("rst_hold");
        rst = 1'b0;
        check("rst.resume_addr", imem_addr, 16'h0000);
        stall = 0;
        cycle("rst.resume");
        check("rst.resume_pp2", ifid_pc_plus2, 16'h0002);

        // PC wrap
        redirect = 1; redirect_pc = 16'hFFFE;
        cycle("wrap_rd");
        redirect = 0;
        cycle("wrap");
        check("wrap.pp2", ifid_pc_plus2, 16'h0000);
        check("wrap.pc", imem_addr, 16'h0000);
        check("wrap.instr", ifid_instr, mem_word(16'hFFFE));

        // odd redirect target taken unmodified
        redirect = 1; redirect_pc = 16'h0333;
        cycle("odd_rd");
        check("odd.pc", imem_addr, 16'h0333);
        redirect = 0;
        cycle("odd_fetch");

        // halt is sticky and ignores everything
        halt_dec = 1;
        cycle("halt");
        check("halt.halted", {15'd0, halted}, 16'h0001);
        check("halt.valid", {15'd0, ifid_valid}, 16'h0000);
        halt_dec = 0;
        redirect = 1; redirect_pc = 16'h0500;
        cycle("halt.rd");
        check("halt.frozen_pc", imem_addr, 16'h0335);
        redirect = 0; siic = 1;
        cycle("halt.siic");
        siic = 0;
        cycle("halt.idle");
        check("halt.still", {15'd0, halted}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("halt.rst_clear", {15'd0, halted}, 16'h0000);
        check_all("halt.rst");
        cycle("halt.rst_hold");
        rst = 1'b0;
        cycle("after_halt");
        check("after_halt.pp2", ifid_pc_plus2, 16'h0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
